// File: rtl/note_pkg.sv
// Shared types and constants for the falling-note spawn controller.
package note_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        PICK = 2'd2,
        HOLD = 2'd3
    } sched_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          LANE_W    = 3;

    typedef logic [LANE_W-1:0] lane_idx_t;

endpackage

// File: rtl/note_lfsr.sv
// 16-bit right-shift Galois LFSR; loads the seed on reset and steps when adv is high.
module note_lfsr
    import note_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) lfsr_q <= seed;
        else       lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;

endmodule

// File: rtl/note_scheduler.sv
// Spawn controller: paces note spawns by frame count and picks an idle lane from the LFSR.
//  state | meaning
//  IDLE  | game stopped, no spawn
//  GAP   | counting frames until the next spawn attempt
//  PICK  | one-cycle lane selection against the current LFSR value
//  HOLD  | spawn level held until the sprites see the next frame edge
module note_scheduler
    import note_pkg::*;
#(
    parameter int          NUM_LANES      = 5,
    parameter logic [7:0]  MIN_GAP_FRAMES = 8'd20,
    parameter logic [2:0]  MAX_ACTIVE     = 3'd3,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic                 enable,
    input  logic [NUM_LANES-1:0] lane_idle,
    output logic [NUM_LANES-1:0] spawn,
    output logic [15:0]          spawn_count,
    output logic [7:0]           skip_count,
    output logic [15:0]          lfsr_out
);

    localparam logic [LANE_W:0] NL = (LANE_W+1)'(NUM_LANES);

    sched_state_t         state_q, state_d;
    logic [7:0]           gap_cnt_q, gap_cnt_d;
    logic                 fc_d_q, fc_d_d;
    logic                 fe_q, fe_d;
    logic [NUM_LANES-1:0] spawn_q, spawn_d;
    logic [15:0]          spawn_count_q, spawn_count_d;
    logic [7:0]           skip_count_q, skip_count_d;

    logic [15:0]          lfsr_val;
    logic                 lfsr_adv;
    lane_idx_t            fold_c;
    lane_idx_t            pick_lane;
    logic                 found;
    logic [LANE_W:0]      idle_cnt;
    logic [LANE_W:0]      active;

    // Same two-flop edge detector as the sprites, so fe lines up with their edge pulse.
    always_comb begin
        fc_d_d = frame_clk;
        fe_d   = frame_clk & ~fc_d_q;
    end

    assign lfsr_adv = fe_q && (state_q != IDLE) && enable;

    note_lfsr u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .adv   (lfsr_adv),
        .seed  (LFSR_SEED),
        .value (lfsr_val)
    );

    always_comb begin
        logic [LANE_W:0] sum;
        lane_idx_t       idx;
        fold_c = lfsr_val[2:0];
        for (int i = 0; i < 4; i++) begin
            if ({1'b0, fold_c} >= NL) fold_c = fold_c - NL[LANE_W-1:0];
        end
        found     = 1'b0;
        pick_lane = '0;
        sum       = '0;
        idx       = '0;
        // Descending scan so the lane closest to fold_c (in rotation order) wins last.
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            sum = {1'b0, fold_c} + k[LANE_W:0];
            if (sum >= NL) sum = sum - NL;
            idx = sum[LANE_W-1:0];
            if (lane_idle[idx]) begin
                found     = 1'b1;
                pick_lane = idx;
            end
        end
        idle_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            idle_cnt = idle_cnt + (LANE_W+1)'(lane_idle[i]);
        end
        active = NL - idle_cnt;
    end

    always_comb begin
        state_d       = state_q;
        gap_cnt_d     = gap_cnt_q;
        spawn_d       = spawn_q;
        spawn_count_d = spawn_count_q;
        skip_count_d  = skip_count_q;
        if (!enable) begin
            state_d = IDLE;
            spawn_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    spawn_d   = '0;
                    state_d   = GAP;
                    gap_cnt_d = MIN_GAP_FRAMES;
                end
                GAP: begin
                    if (fe_q) begin
                        if (gap_cnt_q <= 8'd1) state_d = PICK;
                        else                   gap_cnt_d = gap_cnt_q - 8'd1;
                    end
                end
                PICK: begin
                    if (found && (active < {1'b0, MAX_ACTIVE})) begin
                        state_d            = HOLD;
                        spawn_d            = '0;
                        spawn_d[pick_lane] = 1'b1;
                        spawn_count_d      = spawn_count_q + 16'd1;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = 8'd1;
                        if (skip_count_q != 8'hFF) skip_count_d = skip_count_q + 8'd1;
                    end
                end
                HOLD: begin
                    // Next gap uses the LFSR value from before this edge's advance.
                    if (fe_q) begin
                        state_d   = GAP;
                        gap_cnt_d = MIN_GAP_FRAMES + {4'b0, lfsr_val[11:8]};
                        spawn_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    spawn_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            gap_cnt_q     <= '0;
            fc_d_q        <= 1'b0;
            fe_q          <= 1'b0;
            spawn_q       <= '0;
            spawn_count_q <= '0;
            skip_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            fc_d_q        <= fc_d_d;
            fe_q          <= fe_d;
            spawn_q       <= spawn_d;
            spawn_count_q <= spawn_count_d;
            skip_count_q  <= skip_count_d;
        end
    end

    assign spawn       = spawn_q;
    assign spawn_count = spawn_count_q;
    assign skip_count  = skip_count_q;
    assign lfsr_out    = lfsr_val;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed scenarios plus random lane patterns against a frame-level model.
module tb_note_scheduler;

    localparam int N   = 5;
    localparam int MIN = 4;
    localparam int MAX = 3;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         frame_clk = 1'b0;
    logic         enable = 1'b0;
    logic [N-1:0] lane_idle = '1;
    logic [N-1:0] spawn;
    logic [15:0]  spawn_count;
    logic [7:0]   skip_count;
    logic [15:0]  lfsr_out;

    int n_checks = 0;
    int n_fail   = 0;

    // frame-level reference state
    bit           m_run;
    bit           m_hold;
    int           m_gap;
    logic [15:0]  m_lfsr;
    logic [N-1:0] m_spawn;
    int           m_scnt;
    int           m_skip;

    note_scheduler #(
        .NUM_LANES      (N),
        .MIN_GAP_FRAMES (8'd4),
        .MAX_ACTIVE     (3'd3),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .enable      (enable),
        .lane_idle   (lane_idle),
        .spawn       (spawn),
        .spawn_count (spawn_count),
        .skip_count  (skip_count),
        .lfsr_out    (lfsr_out)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic model_reset();
        m_run = 0; m_hold = 0; m_gap = 0; m_lfsr = 16'hACE1;
        m_spawn = '0; m_scnt = 0; m_skip = 0;
    endtask

    task automatic model_enable();
        m_run = 1; m_hold = 0; m_gap = MIN; m_spawn = '0;
    endtask

    task automatic model_disable();
        m_run = 0; m_hold = 0; m_spawn = '0;
    endtask

    task automatic model_pick();
        int c, act, lane, idx;
        c    = int'(m_lfsr[2:0]) % N;
        act  = N - $countones(lane_idle);
        lane = -1;
        for (int k = 0; k < N; k++) begin
            idx = (c + k) % N;
            if (lane < 0 && lane_idle[3'(idx)]) lane = idx;
        end
        if (lane >= 0 && act < MAX) begin
            m_spawn = '0;
            m_spawn[3'(lane)] = 1'b1;
            m_scnt = (m_scnt + 1) & 16'hFFFF;
            m_hold = 1;
        end else begin
            m_gap = 1;
            if (m_skip < 255) m_skip++;
        end
    endtask

    task automatic model_frame();
        logic [15:0] pre;
        if (!m_run) return;
        pre    = m_lfsr;
        m_lfsr = lfsr_step(m_lfsr);
        if (m_hold) begin
            m_hold  = 0;
            m_spawn = '0;
            m_gap   = MIN + int'(pre[11:8]);
        end else if (m_gap <= 1) begin
            model_pick();
        end else begin
            m_gap--;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".spawn"}, spawn, m_spawn);
        chk({tag, ".spawn_count"}, spawn_count, m_scnt);
        chk({tag, ".skip_count"}, skip_count, m_skip);
        chk({tag, ".lfsr"}, lfsr_out, m_lfsr);
    endtask

    // Called at a negedge; one full frame pulse, settled and checked at the end.
    task automatic do_frame(input string tag);
        frame_clk = 1'b1;
        @(negedge Clk);
        chk({tag, ".spawn_at_fe"}, spawn, m_spawn);
        model_frame();
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        check_model(tag);
    endtask

    task automatic do_reset();
        Reset  = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    logic [15:0] exp_lfsr [4];

    initial begin
        exp_lfsr[0] = 16'hE270; exp_lfsr[1] = 16'h7138;
        exp_lfsr[2] = 16'h389C; exp_lfsr[3] = 16'h1C4E;
        model_reset();

        repeat (3) @(negedge Clk);
        chk("reset.spawn", spawn, 0);
        chk("reset.spawn_count", spawn_count, 0);
        chk("reset.skip_count", skip_count, 0);
        chk("reset.lfsr", lfsr_out, 16'hACE1);
        Reset = 1'b0;

        // first spawn with all lanes idle
        lane_idle = 5'b11111;
        enable = 1'b1; model_enable();
        @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            do_frame("first");
            chk("first.lfsr_seq", lfsr_out, exp_lfsr[i]);
        end
        chk("first.lane1", spawn, 5'b00010);
        do_frame("first.hold_fe");
        chk("first.cleared", spawn, 0);
        for (int i = 0; i < 15; i++) do_frame("gap16");
        chk("gap16.not_yet", spawn_count, 1);
        do_frame("gap16.pick");
        chk("gap16.second", spawn_count, 2);

        // busy lane 1 is skipped
        do_reset();
        lane_idle = 5'b11101;
        enable = 1'b1; model_enable();
        @(negedge Clk);
        for (int i = 0; i < 4; i++) do_frame("busy");
        chk("busy.lane2", spawn, 5'b00100);

        // enable drop while holding
        enable = 1'b0; model_disable();
        @(negedge Clk);
        chk("endrop.spawn", spawn, 0);
        for (int i = 0; i < 3; i++) do_frame("endrop.idle");
        chk("endrop.count_held", spawn_count, 1);

        // MAX_ACTIVE limit
        do_reset();
        lane_idle = 5'b00011;
        enable = 1'b1; model_enable();
        @(negedge Clk);
        for (int i = 0; i < 4; i++) do_frame("maxact");
        chk("maxact.skip1", skip_count, 1);
        for (int i = 0; i < 3; i++) do_frame("maxact.retry");
        chk("maxact.skip4", skip_count, 4);
        lane_idle = 5'b00111;
        do_frame("maxact.release");
        chk("maxact.spawned", spawn_count, 1);

        // reset while holding
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst_hold.spawn", spawn, 0);
        chk("rst_hold.lfsr", lfsr_out, 16'hACE1);
        chk("rst_hold.count", spawn_count, 0);
        Reset = 1'b0;
        model_reset(); model_enable();

        // skip saturation
        lane_idle = 5'b00000;
        @(negedge Clk);
        for (int i = 0; i < 300; i++) do_frame("sat");
        chk("sat.skip_ff", skip_count, 8'hFF);

        // spawn_count wrap
        lane_idle = 5'b11111;
        force dut.spawn_count_q = 16'hFFFF;
        @(negedge Clk);
        release dut.spawn_count_q;
        m_scnt = 16'hFFFF;
        do_frame("wrap");
        chk("wrap.zero", spawn_count, 0);

        // random lane patterns with occasional enable toggles
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(15) == 0) begin
                enable = ~enable;
                if (enable) model_enable();
                else        model_disable();
                @(negedge Clk);
                chk("rand.toggle_spawn", spawn, m_spawn);
            end
            lane_idle = N'($urandom);
            do_frame("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
